// File: rtl/serial_acc_ctrl_if.sv
// Stream bundle for the serial accumulator: control, term input stream and result output.
interface serial_acc_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
);
    logic              start;
    logic              clear;
    logic [ACC_W-1:0]  bias;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              busy;
    logic              ovf;

    // Producer/consumer side (drives control, terms and result ready).
    modport master (
        output start, clear, bias, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    // Accumulator side.
    modport slave (
        input  start, clear, bias, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/serial_acc_ctrl.sv
// Serial saturating reduction of NUM_TERMS signed terms onto a bias through one shared adder.
module serial_acc_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned NUM_TERMS = 784,
    parameter int unsigned CNT_W     = 10
) (
    input logic             clk,
    input logic             rst_n,
    serial_acc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;

    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   sat_val;
    logic [ACC_W-1:0]   acc_next;
    logic               sat;
    logic               beat;
    logic               last_beat;

    // Shared adder with sign-based overflow detection and clamp value.
    always_comb begin
        term_ext  = {{(ACC_W - DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
        sum       = acc_q + term_ext;
        sat       = (acc_q[ACC_W-1] == term_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        // Both operands share a sign on overflow, so acc's sign picks the rail.
        sat_val   = acc_q[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
        acc_next  = sat ? sat_val : sum;
        beat      = bus.in_valid && bus.in_ready;
        last_beat = (cnt_q == CNT_W'(NUM_TERMS - 1));
    end

    // Handshake outputs decoded from state; clear blocks any beat in its cycle.
    assign bus.in_ready  = (state_q == StAccum) && !bus.clear;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;

    // Next-state and datapath updates; clear overrides everything but reset.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        if (bus.clear) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        acc_d   = bus.bias;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StAccum;
                    end
                end
                StAccum: begin
                    if (beat) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + 1'b1;
                        if (sat) begin
                            ovf_d = 1'b1;
                        end
                        if (last_beat) begin
                            out_data_d = acc_next;
                            state_d    = StDone;
                        end
                    end
                end
                StDone: begin
                    // start is ignored here, so consume and start never coincide.
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_serial_acc_ctrl.sv
// Self-checking bench: directed scenarios plus randomized reductions against a saturating model.
module tb_serial_acc_ctrl;
    logic clk;
    logic rst_n;

    // Shared stimulus, routed to the DUT selected by sel (others see idle inputs).
    int          sel;
    logic        start, clear, in_valid, out_ready;
    logic [31:0] bias;
    logic [15:0] in_data;
    logic        o_in_ready, o_out_valid, o_busy, o_ovf;
    logic [31:0] o_out_data;

    int n_checks = 0;
    int n_pass   = 0;

    longint tq[$];

    serial_acc_ctrl_if #(.DATA_W(16), .ACC_W(32)) if_a ();
    serial_acc_ctrl_if #(.DATA_W(8),  .ACC_W(16)) if_s ();
    serial_acc_ctrl_if #(.DATA_W(16), .ACC_W(32)) if_l ();

    serial_acc_ctrl #(.DATA_W(16), .ACC_W(32), .NUM_TERMS(4), .CNT_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    serial_acc_ctrl #(.DATA_W(8), .ACC_W(16), .NUM_TERMS(4), .CNT_W(10)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    serial_acc_ctrl #(.DATA_W(16), .ACC_W(32), .NUM_TERMS(784), .CNT_W(10)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(if_l.slave));

    assign if_a.start = start && (sel == 0);
    assign if_s.start = start && (sel == 1);
    assign if_l.start = start && (sel == 2);
    assign if_a.clear = clear && (sel == 0);
    assign if_s.clear = clear && (sel == 1);
    assign if_l.clear = clear && (sel == 2);
    assign if_a.in_valid = in_valid && (sel == 0);
    assign if_s.in_valid = in_valid && (sel == 1);
    assign if_l.in_valid = in_valid && (sel == 2);
    assign if_a.out_ready = out_ready && (sel == 0);
    assign if_s.out_ready = out_ready && (sel == 1);
    assign if_l.out_ready = out_ready && (sel == 2);
    assign if_a.bias = bias;
    assign if_l.bias = bias;
    assign if_s.bias = bias[15:0];
    assign if_a.in_data = in_data;
    assign if_l.in_data = in_data;
    assign if_s.in_data = in_data[7:0];

    assign o_in_ready  = (sel == 1) ? if_s.in_ready  : (sel == 2) ? if_l.in_ready  : if_a.in_ready;
    assign o_out_valid = (sel == 1) ? if_s.out_valid : (sel == 2) ? if_l.out_valid : if_a.out_valid;
    assign o_busy      = (sel == 1) ? if_s.busy      : (sel == 2) ? if_l.busy      : if_a.busy;
    assign o_ovf       = (sel == 1) ? if_s.ovf       : (sel == 2) ? if_l.ovf       : if_a.ovf;
    assign o_out_data  = (sel == 1) ? {{16{if_s.out_data[15]}}, if_s.out_data} :
                         (sel == 2) ? if_l.out_data : if_a.out_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Saturating reference: add each term in full precision, clamp to the ACC_W range.
    function automatic longint model_reduce(input longint b, input int aw, output bit ov);
        longint mx = (longint'(1) << (aw - 1)) - 1;
        longint mn = -mx - 1;
        longint acc = b;
        ov = 1'b0;
        foreach (tq[i]) begin
            acc = acc + tq[i];
            if (acc > mx) begin acc = mx; ov = 1'b1; end
            else if (acc < mn) begin acc = mn; ov = 1'b1; end
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input longint b);
        start = 1'b1;
        bias  = b[31:0];
        tick();
        start = 1'b0;
    endtask

    task automatic do_beat(input longint t, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = t[15:0];
        while (!o_in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = o_in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Full reduction of tq: start, beats with optional gaps, delayed consume.
    task automatic run_red(input longint b, input int gap_max, input int rdy_wait,
                           output longint res, output bit ov, output bit rdy_lat,
                           output bit val_lat, output bit stable, output bit idle_after,
                           output bit ovf_clr);
        bit ok;
        int n = 0;
        do_start(b);
        rdy_lat = o_in_ready;
        ovf_clr = !o_ovf;
        foreach (tq[i]) begin
            int gaps = 0;
            if (gap_max > 0 && $urandom_range(0, 3) == 0) gaps = $urandom_range(1, gap_max);
            repeat (gaps) tick();
            do_beat(tq[i], ok);
            if (!ok) rdy_lat = 1'b0;
        end
        val_lat = o_out_valid;
        while (!o_out_valid && n < 50) begin
            tick();
            n++;
        end
        res    = longint'($signed(o_out_data));
        ov     = o_ovf;
        stable = o_out_valid;
        repeat (rdy_wait) begin
            tick();
            if (!o_out_valid || longint'($signed(o_out_data)) != res) stable = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        idle_after = !o_out_valid && !o_busy;
    endtask

    task automatic test_reset();
        sel = 0; start = 0; clear = 0; in_valid = 0; out_ready = 0; bias = '0; in_data = '0;
        rst_n = 1'b0;
        #23;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", o_busy); else n_pass++;
        n_checks++; if (o_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", o_in_ready); else n_pass++;
        n_checks++; if (o_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", o_out_valid); else n_pass++;
        n_checks++; if (o_out_data !== 32'd0) $display("FAIL reset_out_data: got %0d want 0", o_out_data); else n_pass++;
        n_checks++; if (o_ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", o_ovf); else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL idle_after_reset: busy %0b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_basic();
        longint res; bit ov, rl, vl, st, ia, oc;
        sel = 0;
        tq = '{1, 2, 3, 4};
        run_red(10, 0, 0, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (res != 20) $display("FAIL basic_result: got %0d want 20", res); else n_pass++;
        n_checks++; if (ov !== 1'b0) $display("FAIL basic_ovf: got %0b want 0", ov); else n_pass++;
        n_checks++; if (rl !== 1'b1) $display("FAIL basic_in_ready_latency: got %0b want 1", rl); else n_pass++;
        n_checks++; if (vl !== 1'b1) $display("FAIL basic_out_valid_latency: got %0b want 1", vl); else n_pass++;
        n_checks++; if (ia !== 1'b1) $display("FAIL basic_idle_after_consume: got %0b want 1", ia); else n_pass++;
    endtask

    task automatic test_stall();
        longint res; bit ov, rl, vl, st, ia, oc;
        bit seen_valid = 1'b0;
        sel = 0;
        tq = '{1, 2, 3, 4};
        run_red(10, 3, 5, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (res != 20) $display("FAIL stall_result: got %0d want 20", res); else n_pass++;
        n_checks++; if (st !== 1'b1) $display("FAIL stall_stable: got %0b want 1", st); else n_pass++;
        n_checks++; if (vl !== 1'b1) $display("FAIL stall_out_valid_latency: got %0b want 1", vl); else n_pass++;
        n_checks++; if (ia !== 1'b1) $display("FAIL stall_idle_after_consume: got %0b want 1", ia); else n_pass++;
        repeat (3) begin
            tick();
            if (o_out_valid) seen_valid = 1'b1;
        end
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL stall_single_consume: out_valid %0b want 0", seen_valid); else n_pass++;
        n_checks++; if (o_out_data !== 32'd20) $display("FAIL stall_hold_in_idle: got %0d want 20", o_out_data); else n_pass++;
    endtask

    task automatic test_saturation();
        longint res; bit ov, rl, vl, st, ia, oc;
        sel = 1;
        tq = '{127, 127, 127, 127};
        run_red(32760, 0, 2, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (res != 32767) $display("FAIL sat_pos_result: got %0d want 32767", res); else n_pass++;
        n_checks++; if (ov !== 1'b1) $display("FAIL sat_pos_ovf: got %0b want 1", ov); else n_pass++;
        tick();
        n_checks++; if (o_ovf !== 1'b1) $display("FAIL sat_ovf_sticky: got %0b want 1", o_ovf); else n_pass++;
        tq = '{-128, -128, -128, -128};
        run_red(-32760, 0, 0, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (oc !== 1'b1) $display("FAIL sat_ovf_cleared_at_start: got %0b want 1", oc); else n_pass++;
        n_checks++; if (res != -32768) $display("FAIL sat_neg_result: got %0d want -32768", res); else n_pass++;
        n_checks++; if (ov !== 1'b1) $display("FAIL sat_neg_ovf: got %0b want 1", ov); else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        sel = 0;
        do_start(100);
        do_beat(5, ok);
        do_beat(6, ok);
        start = 1'b1;
        bias  = 32'd7777;
        do_beat(7, ok);
        start = 1'b0;
        do_beat(8, ok);
        start = 1'b1;
        bias  = 32'd1;
        tick();
        n_checks++; if (o_out_valid !== 1'b1) $display("FAIL start_in_done_valid: got %0b want 1", o_out_valid); else n_pass++;
        n_checks++; if (o_out_data !== 32'd126) $display("FAIL start_ignored_result: got %0d want 126", o_out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL start_with_consume: busy %0b want 0", o_busy); else n_pass++;
        tick();
        n_checks++; if (o_busy !== 1'b0) $display("FAIL start_with_consume_idle: busy %0b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_clear();
        bit ok;
        bit seen_valid = 1'b0;
        longint res; bit ov, rl, vl, st, ia, oc;
        sel = 0;
        do_start(50);
        do_beat(1, ok);
        do_beat(2, ok);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd100;
        #1;
        n_checks++; if (o_in_ready !== 1'b0) $display("FAIL clear_blocks_ready: got %0b want 0", o_in_ready); else n_pass++;
        tick();
        clear = 1'b0;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL clear_to_idle: busy %0b want 0", o_busy); else n_pass++;
        n_checks++; if (o_out_data !== 32'd126) $display("FAIL clear_holds_out_data: got %0d want 126", o_out_data); else n_pass++;
        repeat (5) begin
            if (o_out_valid || o_in_ready) seen_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL clear_no_output: got %0b want 0", seen_valid); else n_pass++;
        tq = '{1, 1, 1, 1};
        run_red(0, 0, 0, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (res != 4) $display("FAIL clear_fresh_result: got %0d want 4", res); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        longint res; bit ov, rl, vl, st, ia, oc;
        sel = 0;
        do_start(1000);
        do_beat(10, ok);
        do_beat(20, ok);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL async_busy: got %0b want 0", o_busy); else n_pass++;
        n_checks++; if (o_in_ready !== 1'b0) $display("FAIL async_in_ready: got %0b want 0", o_in_ready); else n_pass++;
        n_checks++; if (o_out_data !== 32'd0) $display("FAIL async_out_data: got %0d want 0", o_out_data); else n_pass++;
        #2 rst_n = 1'b1;
        tick();
        tq = '{1, 2, 3, 4};
        run_red(-10, 0, 0, res, ov, rl, vl, st, ia, oc);
        n_checks++; if (res != 0) $display("FAIL async_fresh_result: got %0d want 0", res); else n_pass++;
    endtask

    task automatic test_random(input int s, input int n_red, input int gap_max);
        int     nt   = (s == 2) ? 784 : 4;
        int     dw   = (s == 1) ? 8 : 16;
        int     aw   = (s == 1) ? 16 : 32;
        longint mx   = (longint'(1) << (aw - 1)) - 1;
        longint mn   = -mx - 1;
        longint ht   = longint'(1) << (dw - 1);
        int     span = (s == 2) ? 20000000 : 600;
        sel = s;
        for (int r = 0; r < n_red; r++) begin
            int          mode;
            int          bc;
            logic [31:0] rv;
            longint      b, res, exp_res;
            bit          ov, exp_ov, rl, vl, st, ia, oc;
            mode = $urandom_range(0, 2);
            bc   = $urandom_range(0, 2);
            rv   = $urandom;
            if (bc == 0) b = (aw == 16) ? longint'($signed(rv[15:0])) : longint'($signed(rv));
            else if (bc == 1) b = mx - longint'($urandom_range(0, span));
            else b = mn + longint'($urandom_range(0, span));
            tq.delete();
            for (int i = 0; i < nt; i++) begin
                if (mode == 0) tq.push_back(longint'($urandom_range(0, 32'(2 * ht - 1))) - ht);
                else if (mode == 1) tq.push_back(longint'($urandom_range(0, 32'(ht - 1))));
                else tq.push_back(-longint'($urandom_range(0, 32'(ht))));
            end
            exp_res = model_reduce(b, aw, exp_ov);
            run_red(b, gap_max, $urandom_range(0, 3), res, ov, rl, vl, st, ia, oc);
            n_checks++; if (res != exp_res) $display("FAIL rand%0d_result[%0d]: got %0d want %0d", s, r, res, exp_res); else n_pass++;
            n_checks++; if (ov !== exp_ov) $display("FAIL rand%0d_ovf[%0d]: got %0b want %0b", s, r, ov, exp_ov); else n_pass++;
            n_checks++; if ({rl, vl, st, ia, oc} !== 5'b11111) $display("FAIL rand%0d_protocol[%0d]: got %05b want 11111", s, r, {rl, vl, st, ia, oc}); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_start_ignored();
        test_clear();
        test_async_reset();
        test_random(0, 200, 3);
        test_random(1, 200, 3);
        test_random(2, 30, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
